// File: rtl/rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// rom_access_arbiter
//
// Shares one program ROM (combinational data) between two requesters:
//   port 0 - core instruction fetch (fixed priority)
//   port 1 - debug / readback path (starvation-bounded)
// Each cycle at most one request is granted. The winner's address is
// registered onto rom_address, and the ROM word is registered back to the
// winner one edge later, so the valid pulse lands two cycles after the grant.
//
// Parameters:
//   ADDR_W       ROM address width
//   DATA_W       ROM data width
//   STARVE_LIMIT consecutive lost cycles after which port 1 is promoted;
//                0 gives pure fixed priority
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req0/addr0            port 0 request and address (held until gnt0)
//   gnt0                  combinational accept for port 0
//   valid0/data0          registered one-cycle return pulse and data, port 0
//   req1/addr1/gnt1/valid1/data1   same for port 1
//   rom_address           registered address to the ROM
//   rom_dataout           combinational ROM data for rom_address
// -----------------------------------------------------------------------------
module rom_access_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              valid0,
    output logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              valid1,
    output logic [DATA_W-1:0] data1,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_dataout
);

    // A zero limit still needs a one-bit counter so the declaration stays legal;
    // promotion is then disabled by PROMO_EN.
    localparam int               CNT_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             PROMO_EN = (STARVE_LIMIT != 0);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             a_vld_r;
    logic             a_own_r;   // 1'b0 = port 0 owns stage A, 1'b1 = port 1

    // Arbitration: promoted port 1 first, then fixed priority to port 0.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req1 && PROMO_EN && (starve_cnt_r == LIMIT_C)) begin
            gnt1_s = 1'b1;
        end else if (req0) begin
            gnt0_s = 1'b1;
        end else if (req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Grants are forced low while reset is asserted, even if requests are high.
    assign gnt0 = gnt0_s & rst_n;
    assign gnt1 = gnt1_s & rst_n;

    // Starvation counter: counts cycles port 1 waits, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!req1 || gnt1_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Stage A: register the winning address and tag it with its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_address <= {ADDR_W{1'b0}};
            a_vld_r     <= 1'b0;
            a_own_r     <= 1'b0;
        end else if (gnt0_s) begin
            rom_address <= addr0;
            a_vld_r     <= 1'b1;
            a_own_r     <= 1'b0;
        end else if (gnt1_s) begin
            rom_address <= addr1;
            a_vld_r     <= 1'b1;
            a_own_r     <= 1'b1;
        end else begin
            // Idle: address bus holds so the ROM output does not toggle.
            rom_address <= rom_address;
            a_vld_r     <= 1'b0;
            a_own_r     <= a_own_r;
        end
    end

    // Stage B: capture ROM data into the owning port only; valid is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            data0  <= {DATA_W{1'b0}};
            data1  <= {DATA_W{1'b0}};
        end else begin
            valid0 <= a_vld_r & ~a_own_r;
            valid1 <= a_vld_r & a_own_r;
            if (a_vld_r && !a_own_r) begin
                data0 <= rom_dataout;
            end else begin
                data0 <= data0;
            end
            if (a_vld_r && a_own_r) begin
                data1 <= rom_dataout;
            end else begin
                data1 <= data1;
            end
        end
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_access_arbiter
//
// Two arbiter instances share one set of requester inputs: dut_a uses
// STARVE_LIMIT=4, dut_b uses STARVE_LIMIT=0. Each has its own ROM model.
// Inputs change on the falling edge; grants are checked 1 time unit later,
// registered outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_rom_access_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [7:0] addr0;
    logic       req1;
    logic [7:0] addr1;

    logic       gnt0_a, valid0_a, gnt1_a, valid1_a;
    logic [7:0] data0_a, data1_a, rom_addr_a, rom_data_a;
    logic       gnt0_b, valid0_b, gnt1_b, valid1_b;
    logic [7:0] data0_b, data1_b, rom_addr_b, rom_data_b;

    int n_cmp;
    int n_bad;

    // ROM contents: 0x00..0x15 populated, everything else reads 0x00.
    function automatic logic [7:0] rom_word(input logic [7:0] a);
        case (a)
            8'h00: rom_word = 8'h5A;  8'h01: rom_word = 8'h86;
            8'h02: rom_word = 8'h13;  8'h03: rom_word = 8'hC4;
            8'h04: rom_word = 8'h27;  8'h05: rom_word = 8'h9B;
            8'h06: rom_word = 8'h3E;  8'h07: rom_word = 8'hF0;
            8'h08: rom_word = 8'h61;  8'h09: rom_word = 8'hA8;
            8'h0A: rom_word = 8'h0D;  8'h0B: rom_word = 8'h72;
            8'h0C: rom_word = 8'hE5;  8'h0D: rom_word = 8'h4C;
            8'h0E: rom_word = 8'hB9;  8'h0F: rom_word = 8'h1F;
            8'h10: rom_word = 8'h96;  8'h11: rom_word = 8'h2B;
            8'h12: rom_word = 8'hD3;  8'h13: rom_word = 8'h48;
            8'h14: rom_word = 8'h7E;  8'h15: rom_word = 8'hC1;
            default: rom_word = 8'h00;
        endcase
    endfunction

    assign rom_data_a = rom_word(rom_addr_a);
    assign rom_data_b = rom_word(rom_addr_b);

    rom_access_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .valid0(valid0_a), .data0(data0_a),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .valid1(valid1_a), .data1(data1_a),
        .rom_address(rom_addr_a), .rom_dataout(rom_data_a)
    );

    rom_access_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .valid0(valid0_b), .data0(data0_b),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .valid1(valid1_b), .data1(data1_b),
        .rom_address(rom_addr_b), .rom_dataout(rom_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1'b0; addr0 = 8'h00; req1 = 1'b0; addr1 = 8'h00;
        repeat (2) @(negedge clk);
        req0 = 1'b1; addr0 = 8'h09;
        #1;
        n_cmp++;
        if ({gnt0_a, gnt1_a, valid0_a, valid1_a} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {gnt0_a, gnt1_a, valid0_a, valid1_a});
        end
        n_cmp++;
        if ({rom_addr_a, data0_a, data1_a} !== 24'h000000) begin
            n_bad++; $display("FAIL reset_regs: got %h want 000000", {rom_addr_a, data0_a, data1_a});
        end
        req0 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        // Mid-stream reset: grant 0x05, then assert reset while it is in flight.
        @(negedge clk); req0 = 1'b1; addr0 = 8'h05;
        @(negedge clk); req0 = 1'b0;
        n_cmp++;
        if (rom_addr_a !== 8'h05) begin
            n_bad++; $display("FAIL midrst_pre: got %h want 05", rom_addr_a);
        end
        #2 rst_n = 1'b0; req0 = 1'b1;
        #1;
        n_cmp++;
        if ({gnt0_a, gnt1_a, valid0_a, valid1_a, rom_addr_a, data0_a, data1_a} !== 28'h0) begin
            n_bad++; $display("FAIL midrst_outs: got %h want 0", {gnt0_a, gnt1_a, valid0_a, valid1_a, rom_addr_a, data0_a, data1_a});
        end
        req0 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({valid0_a, valid1_a} !== 2'b00) begin
                n_bad++; $display("FAIL midrst_novalid[%0d]: got %b want 00", i, {valid0_a, valid1_a});
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk); req0 = 1'b1; addr0 = 8'h01;
        #1;
        n_cmp++;
        if ({gnt0_a, gnt1_a} !== 2'b10) begin
            n_bad++; $display("FAIL single_gnt: got %b want 10", {gnt0_a, gnt1_a});
        end
        @(negedge clk); req0 = 1'b0;
        n_cmp++;
        if ({rom_addr_a, valid0_a} !== {8'h01, 1'b0}) begin
            n_bad++; $display("FAIL single_addr: got %h/%b want 01/0", rom_addr_a, valid0_a);
        end
        @(negedge clk);
        n_cmp++;
        if ({valid0_a, data0_a} !== {1'b1, 8'h86}) begin
            n_bad++; $display("FAIL single_data: got %b/%h want 1/86", valid0_a, data0_a);
        end
        @(negedge clk);
        n_cmp++;
        if ({valid0_a, data0_a} !== {1'b0, 8'h86}) begin
            n_bad++; $display("FAIL single_hold: got %b/%h want 0/86", valid0_a, data0_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i < 23) begin
                a = 8'(i); req0 = 1'b1; addr0 = a;
            end else begin
                req0 = 1'b0;
            end
            #1;
            if (i < 23) begin
                n_cmp++;
                if (gnt0_a !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, gnt0_a);
                end
            end
            if (i >= 2) begin
                a = 8'(i - 2);
                n_cmp++;
                if ({valid0_a, data0_a} !== {1'b1, rom_word(a)}) begin
                    n_bad++; $display("FAIL b2b_data[%0d]: got %b/%h want 1/%h", i, valid0_a, data0_a, rom_word(a));
                end
            end else begin
                n_cmp++;
                if (valid0_a !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_lead[%0d]: got %b want 0", i, valid0_a);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({valid0_a, data0_a} !== {1'b0, 8'h00}) begin
            n_bad++; $display("FAIL b2b_tail: got %b/%h want 0/00", valid0_a, data0_a);
        end
    endtask

    task automatic test_contention();
        logic exp_g1;
        logic exp_v1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req0 = 1'b1; addr0 = 8'h03; req1 = 1'b1; addr1 = 8'h10;
            #1;
            exp_g1 = ((k % 5) == 4);
            exp_v1 = (k >= 2) && (((k - 2) % 5) == 4);
            n_cmp++;
            if ({gnt0_a, gnt1_a} !== {~exp_g1, exp_g1}) begin
                n_bad++; $display("FAIL cont_gnt[%0d]: got %b want %b", k, {gnt0_a, gnt1_a}, {~exp_g1, exp_g1});
            end
            if (k >= 2) begin
                n_cmp++;
                if ({valid0_a, valid1_a} !== {~exp_v1, exp_v1}) begin
                    n_bad++; $display("FAIL cont_valid[%0d]: got %b want %b", k, {valid0_a, valid1_a}, {~exp_v1, exp_v1});
                end
            end
            if (exp_v1) begin
                n_cmp++;
                if ({data1_a, data0_a} !== {8'h96, 8'hC4}) begin
                    n_bad++; $display("FAIL cont_data[%0d]: got %h/%h want 96/c4", k, data1_a, data0_a);
                end
            end
        end
        @(negedge clk); req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_starve();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req0 = 1'b1; addr0 = 8'h04; req1 = 1'b1; addr1 = 8'h11;
            #1;
            n_cmp++;
            if ({gnt0_b, gnt1_b} !== 2'b10) begin
                n_bad++; $display("FAIL nostarve_gnt[%0d]: got %b want 10", k, {gnt0_b, gnt1_b});
            end
        end
        @(negedge clk); req0 = 1'b0;
        #1;
        n_cmp++;
        if ({gnt0_b, gnt1_b} !== 2'b01) begin
            n_bad++; $display("FAIL nostarve_drop: got %b want 01", {gnt0_b, gnt1_b});
        end
        @(negedge clk); req1 = 1'b0;
        n_cmp++;
        if (rom_addr_b !== 8'h11) begin
            n_bad++; $display("FAIL nostarve_addr: got %h want 11", rom_addr_b);
        end
        @(negedge clk);
        n_cmp++;
        if ({valid0_b, valid1_b, data1_b} !== {2'b01, 8'h2B}) begin
            n_bad++; $display("FAIL nostarve_data: got %b/%h want 01/2b", {valid0_b, valid1_b}, data1_b);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_interleave();
        // Entering state of dut_a: data0 = word 0x04 (27), data1 = word 0x11 (2b).
        logic [7:0] e_d0 [0:4];
        logic [7:0] e_d1 [0:4];
        logic [1:0] e_v  [0:4];
        e_d0 = '{8'h27, 8'h27, 8'h13, 8'h13, 8'h0D};
        e_d1 = '{8'h2B, 8'h2B, 8'h2B, 8'hF0, 8'hF0};
        e_v  = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req0 = 1'b0; req1 = 1'b0;
            if (k == 0) begin req0 = 1'b1; addr0 = 8'h02; end
            if (k == 1) begin req1 = 1'b1; addr1 = 8'h07; end
            if (k == 2) begin req0 = 1'b1; addr0 = 8'h0A; end
            #1;
            n_cmp++;
            if ({valid0_a, valid1_a, data0_a, data1_a} !== {e_v[k], e_d0[k], e_d1[k]}) begin
                n_bad++; $display("FAIL inter[%0d]: got %b/%h/%h want %b/%h/%h", k, {valid0_a, valid1_a}, data0_a, data1_a, e_v[k], e_d0[k], e_d1[k]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_no_starve();
        test_interleave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Shares the single program ROM (8-bit address, 8-bit combinational data) between two requesters: port 0, the core's instruction fetch, and port 1, the debug/readback path. Each cycle it grants at most one request, registers the winning address onto the ROM address bus and returns the registered ROM data to the winner two cycles later. Port 0 has fixed priority, and a starvation counter bounds the wait on port 1. The block sits between the core/debug logic and the ROM instance.

## Interface
- ADDR_W, 8, ROM address width
- DATA_W, 8, ROM data width
- STARVE_LIMIT, 4, consecutive lost cycles after which port 1 wins; 0 disables starvation promotion (pure fixed priority)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  port 0 request, held until gnt0
- addr0  in  ADDR_W  port 0 address, stable while req0
- gnt0  out  1  combinational, port 0 request accepted this cycle
- valid0  out  1  registered, one-cycle pulse: data0 valid
- data0  out  DATA_W  registered ROM data for port 0
- req1, addr1, gnt1, valid1, data1  same as above for port 1
- rom_address  out  ADDR_W  registered address to ROM
- rom_dataout  in  DATA_W  combinational ROM data for rom_address

## Operation
- Arbitration is combinational within a cycle and uses req0, req1 and starve_cnt:
  - if req1 && STARVE_LIMIT!=0 && starve_cnt==STARVE_LIMIT: port 1 wins;
  - else if req0: port 0 wins;
  - else if req1: port 1 wins;
  - else no grant.
- Exactly one of gnt0/gnt1 is high in a winning cycle; neither is high otherwise. gnt is never high without the matching req.
- Pipeline, with a registered owner tag per stage:
  - stage A, at the edge ending the accept cycle: rom_address <= winner addr; a_vld <= 1; a_own <= winner.
  - stage B, next edge: data_own <= rom_dataout; valid_own <= a_vld.
- Throughput is one access per cycle with back-to-back grants.
- With no grant, a_vld <= 0 and rom_address holds its last value.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - clears when req1==0 or gnt1==1;
  - otherwise increments, saturating at STARVE_LIMIT.
- data0/data1 hold their value between valid pulses; only the owning port's data register updates.
- No backpressure on return data: valid is a pulse the requester must capture.

## Timing
- Reset (async assert, sync-released by the system) sets: rom_address=0, valid0=valid1=0, data0=data1=0, a_vld=0, starve_cnt=0. gnt0/gnt1 follow req combinationally even during reset? No: gnt0=gnt1=0 while rst_n==0.
- Latency: request accepted in cycle N (gnt high) -> rom_address updated at edge N -> valid pulse during cycle N+2.
- Requester may change addr/req in cycle N+1 after seeing gnt in cycle N.
- Simultaneous req0 & req1 with starve_cnt<limit: gnt0; req1 keeps waiting and starve_cnt increments.
- Worst-case port 1 wait: STARVE_LIMIT+1 cycles from first req1 to gnt1.
- Reset mid-operation: in-flight accesses are discarded and no valid pulse appears after rst_n rises; a port must re-request.
- Address wrap: rom_address is the addr bits verbatim; no arithmetic or increment.

## Test plan
- Reset: drive rst_n=0 mid-stream -> all outputs 0 immediately; no valid pulse within 3 cycles after release with req low.
- Single port 0: req0 with addr0=0x01 in cycle 0 -> gnt0 in cycle 0; rom_address=0x01 from cycle 1; valid0 in cycle 2 with data0=0x86 (ROM word at 0x01).
- Back-to-back port 0 streaming addresses 0x00..0x15 -> one valid0 per cycle, 2-cycle lag, data matching the ROM words; address 0x16 returns 0x00 (default).
- Contention, STARVE_LIMIT=4: req0 and req1 held continuously -> gnt0 for 4 cycles, gnt1 on the 5th, and the pattern repeats. valid1 carries data for addr1 and data0 is unchanged in that cycle.
- STARVE_LIMIT=0 with both requesting -> gnt1 never asserts while req0 is high; gnt1 follows in the first cycle req0 drops.
- Interleaved owners: alternating single grants 0,1,0 -> valid0/valid1 pulses alternate in the same order, and each data register updates only on its own pulse.
